// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider for the execute stage (div/mod, signed/unsigned).
// Optional early-out for |dividend| < |divisor| when DIV_EARLY_OUT_EN is defined.
module ex_div #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             annul,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             stall_req
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_END  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0] counter;
  logic [WIDTH-1:0] part_rem;
  logic [WIDTH-1:0] dvd_sh;
  logic [WIDTH-1:0] dvs_mag;
  logic             q_neg;
  logic             r_neg;

  logic             accept;
  logic             div_zero;
  logic             early_out;
  logic             last_iter;
  logic             q_bit;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;
  logic [WIDTH:0]   trial_rem;
  logic [WIDTH:0]   trial_diff;
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] r_final;

  // Operand magnitudes and one restoring step of the shift/subtract datapath
  always_comb begin
    dvd_abs    = (signed_div && dividend[WIDTH-1]) ? WIDTH'(-dividend) : dividend;
    dvs_abs    = (signed_div && divisor[WIDTH-1])  ? WIDTH'(-divisor)  : divisor;
    div_zero   = (divisor == '0);
    accept     = (state == S_IDLE) && start && !annul;
`ifdef DIV_EARLY_OUT_EN
    early_out  = (dvd_abs < dvs_abs) && !div_zero;
`else
    early_out  = 1'b0;
`endif
    trial_rem  = {part_rem, dvd_sh[WIDTH-1]};
    trial_diff = trial_rem - {1'b0, dvs_mag};
    q_bit      = ~trial_diff[WIDTH];
    last_iter  = (counter == CNT_W'(WIDTH - 1));
    q_final    = {dvd_sh[WIDTH-2:0], q_bit};
    r_final    = q_bit ? trial_diff[WIDTH-1:0] : trial_rem[WIDTH-1:0];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; annul overrides everything
  always_comb begin
    state_next = state;
    if (annul) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start) state_next = (div_zero || early_out) ? S_END : S_ON;
        S_ON:   if (last_iter) state_next = S_END;
        S_END:  if (!start) state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Combinational pipeline hold request
  always_comb begin
    stall_req = start && !done;
  end

  // Datapath and registered results
  always_ff @(posedge clk) begin
    if (rst) begin
      quotient  <= '0;
      remainder <= '0;
      done      <= 1'b0;
      counter   <= '0;
      part_rem  <= '0;
      dvd_sh    <= '0;
      dvs_mag   <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
    end else begin
      done <= (state_next == S_END);
      case (state)
        S_IDLE: begin
          if (accept) begin
            dvd_sh   <= dvd_abs;
            dvs_mag  <= dvs_abs;
            q_neg    <= signed_div & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg    <= signed_div & dividend[WIDTH-1];
            part_rem <= '0;
            counter  <= '0;
            if (div_zero) begin
              quotient  <= '1;
              remainder <= dividend;
            end else if (early_out) begin
              quotient  <= '0;
              remainder <= dividend;
            end
          end
        end
        S_ON: begin
          if (!annul) begin
            part_rem <= r_final;
            dvd_sh   <= q_final;
            counter  <= counter + CNT_W'(1);
            if (last_iter) begin
              quotient  <= q_neg ? WIDTH'(-q_final) : q_final;
              remainder <= r_neg ? WIDTH'(-r_final) : r_final;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ex_div.md
Name: ex_div

Overview:
- Iterative radix-2 restoring divider for the execute stage.
- Consumes operands and the divide opcode that arrive from the ID/EX pipeline register.
- Serves div.w, div.wu, mod.w and mod.wu; the EX mux selects quotient or remainder.
- Holds the pipeline via stall_req until the result is ready, and can be annulled by a pipeline flush.

Parameters:
- WIDTH, 32, operand and result width in bits. The iteration counter is clog2(WIDTH)+1 bits.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  divide request. EX drives it as is_div_op && !done.
- annul  input  1  flush; abandons any operation in progress.
- signed_div  input  1  1 = signed (div.w/mod.w), 0 = unsigned.
- dividend  input  WIDTH  sampled only on the accept cycle.
- divisor  input  WIDTH  sampled only on the accept cycle.
- quotient  output  WIDTH  registered result.
- remainder  output  WIDTH  registered result.
- done  output  1  result valid; high only in state END.
- stall_req  output  1  combinational: start && !done. Routed to the pipeline controller.

Behaviour:
- Interface: one clock; reset is synchronous and active-high; ports named clk and rst.
- Reset (rst=1 at an edge), including mid-operation:
  - state=IDLE, quotient=0, remainder=0, done=0, counter=0, internal partial remainder=0.
- States: IDLE, ON, END (2-bit encoding).
- IDLE:
  - If start && !annul: latch operands. In signed mode take absolute values and record q_neg = dividend[MSB]^divisor[MSB] and r_neg = dividend[MSB].
  - If divisor==0: go to END with quotient=all ones and remainder=dividend (raw input).
  - Otherwise go to ON with counter=0.
- ON, one bit per cycle:
  - Shift {partial remainder, dividend} left by 1.
  - Trial subtraction is WIDTH+1 bits wide. If non-negative, keep the difference and shift in quotient bit 1; else shift in 0.
  - counter increments each cycle.
  - When counter==WIDTH-1 the iteration completes. At the same edge:
    - quotient <= q_neg ? -q : q
    - remainder <= r_neg ? -r : r
    - state <= END.
- END: done=1. Go to IDLE when start==0; stay in END while start==1.
- Consumer rule: EX gates start with done. The pipeline advances on the same edge that END→IDLE occurs, so back-to-back divides are accepted the cycle after done.
- annul:
  - In any state, annul=1 at an edge forces IDLE.
  - quotient and remainder keep their prior values; done=0 the following cycle.
  - annul has priority over start.
- Latency:
  - Start sampled in cycle 0 → done in cycle WIDTH+1 (cycle 33 at WIDTH=32).
  - Divide-by-zero → done in cycle 1.
- Signed arithmetic:
  - Magnitude math is unsigned, so |INT_MIN| = 0x80000000 is representable.
  - 0x80000000 / -1 gives quotient 0x80000000, remainder 0.
- Operand changes while in ON or END have no effect.
- Results hold stable between operations; they change only at completion or reset.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in IDLE on accept, if |dividend| < |divisor| (unsigned compare after the abs step) and divisor != 0, go straight to END with quotient=0 and remainder=dividend (raw input). done appears in cycle 1.
- Undefined: all non-zero-divisor operations take the full WIDTH iterations. Results are identical either way; only latency differs.

Test Plan:
- Unsigned: start, signed_div=0, 100/7 → done in cycle 33, quotient=14, remainder=2; stall_req high in cycles 0–32, low in cycle 33.
- Signed: -7/2 (0xFFFFFFF9 / 0x2) → quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1).
- Overflow and zero divisor:
  - 0x80000000 / 0xFFFFFFFF signed → quotient=0x80000000, remainder=0.
  - 5/0 → done in cycle 1, quotient=0xFFFFFFFF, remainder=5.
- Annul: assert annul in cycle 10 of 100/7 → state IDLE at cycle 11, done never asserts, quotient/remainder keep the previous result. A new 9/3 then completes with quotient=3, remainder=0.
- Back-to-back: 50/5 then 81/9 with start gated by done → second accepted the cycle after the first done; results 10/0 then 9/0. Also rst mid-ON clears all outputs to 0.
- With DIV_EARLY_OUT_EN defined: 3/10 → done in cycle 1, quotient=0, remainder=3. Without the macro the same operation completes in cycle 33 with identical values.
